prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Streams a byte-serial program into instruction memory as 32-bit
//             big-endian words while holding the CPU, then releases it.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        pc_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_recv   = 2'd1;
    localparam logic [1:0]  c_st_write  = 2'd2;
    localparam logic [1:0]  c_st_done   = 2'd3;
    localparam logic [31:0] c_max_words = MAX_WORDS;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [15:0] r_count;
    logic [15:0] r_widx;
    logic [1:0]  r_bidx;
    logic [23:0] r_shift;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;

    logic        w_start_ok;
    logic        w_too_many;
    logic        w_accept;
    logic        w_last_byte;
    logic [15:0] w_widx_inc;

    assign w_start_ok  = (r_state == c_st_idle) && start;
    assign w_too_many  = {16'd0, word_count} > c_max_words;
    assign w_accept    = (r_state == c_st_recv) && in_valid;
    assign w_last_byte = w_accept && (r_bidx == 2'd3);
    assign w_widx_inc  = r_widx + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    // Empty or oversized loads finish immediately without touching memory
                    if ((word_count == 16'd0) || w_too_many) begin
                        w_next = c_st_done;
                    end else begin
                        w_next = c_st_recv;
                    end
                end
            end
            c_st_recv: begin
                if (w_last_byte) begin
                    w_next = c_st_write;
                end
            end
            c_st_write: begin
                w_next = (w_widx_inc == r_count) ? c_st_done : c_st_recv;
            end
            c_st_done: begin
                w_next = c_st_idle;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
            r_widx  <= 16'd0;
            r_bidx  <= 2'd0;
            r_shift <= 24'd0;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_count <= word_count;
                r_widx  <= 16'd0;
                r_bidx  <= 2'd0;
                r_addr  <= BASE_ADDR;
                r_err   <= w_too_many;
            end
            if (w_accept) begin
                r_shift <= {r_shift[15:0], in_data};
                r_bidx  <= r_bidx + 2'd1;
            end
            // Memory-side outputs are loaded together so they stay frozen outside WRITE
            if (w_last_byte) begin
                r_we    <= 1'b1;
                r_wdata <= {r_shift, in_data};
                r_addr  <= BASE_ADDR + {14'd0, r_widx, 2'b00};
            end
            if (r_state == c_st_write) begin
                r_we   <= 1'b0;
                r_widx <= w_widx_inc;
            end
        end
    end

    assign in_ready = (r_state == c_st_recv);
    assign busy     = (r_state != c_st_idle);
    assign cpu_hold = busy;
    assign done     = (r_state == c_st_done);
    assign pc_reset = done;
    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        pc_reset;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader #(
        .MAX_WORDS (256),
        .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .pc_reset   (pc_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    logic [7:0]  stream [0:15];
    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];
    int          wr_n;
    int          done_n;
    int          done_cyc;
    logic        done_err;
    int          viol     = 0;
    logic        prev_we  = 1'b0;
    int          start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: logs writes and done pulses, flags handshake/strobe violations
    always @(negedge clk) begin
        if (!rst) begin
            if (im_we) begin
                if (wr_n < 16) begin
                    wa[wr_n] = im_addr;
                    wd[wr_n] = im_wdata;
                end
                wr_n = wr_n + 1;
            end
            if (done) begin
                done_n   = done_n + 1;
                done_cyc = cyc;
                done_err = err;
                if (!pc_reset) viol = viol + 1;
            end
            if (im_we && in_ready) viol = viol + 1;
            if (im_we && prev_we)  viol = viol + 1;
            if (cpu_hold != busy)  viol = viol + 1;
            prev_we = im_we;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_stream(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [95:0] all;
        all = {w0, w1, w2};
        for (int i = 0; i < 12; i++) stream[i] = all[95 - 8*i -: 8];
    endtask

    task automatic run_load(input logic [15:0] cnt, input int nbytes, input bit toggle,
                            input bit restart, input int stop_after);
        int idx   = 0;
        int guard = 0;
        bit acc;
        bit ph    = 1'b0;
        wr_n   = 0;
        done_n = 0;
        @(negedge clk); #1;
        start      = 1'b1;
        word_count = cnt;
        start_cyc  = cyc;
        @(negedge clk); #1;
        while ((done_n == 0) && (guard < 300) && !((stop_after >= 0) && (idx >= stop_after))) begin
            ph       = ~ph;
            in_valid = (idx < nbytes) && (!toggle || ph);
            in_data  = stream[idx % 16];
            if (restart && (guard == 2)) begin
                start      = 1'b1;
                word_count = 16'd1;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk); #1;
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("load_timeout", {31'd0, guard < 300}, 32'd1);
    endtask

    task automatic settle;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = 16'd0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        wr_n       = 0;
        done_n     = 0;
        done_cyc   = 0;
        done_err   = 1'b0;
        #12;
        check("rst_busy",   {31'd0, busy},     32'd0);
        check("rst_ready",  {31'd0, in_ready}, 32'd0);
        check("rst_addr",   im_addr,           32'h0);
        check("rst_wdata",  im_wdata,          32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two words, continuous stream
        set_stream(32'h2008_0005, 32'h0109_5020, 32'h0);
        run_load(16'd2, 8, 1'b0, 1'b0, -1);
        check("s1_nwr",   wr_n,        32'd2);
        check("s1_a0",    wa[0],       32'h0);
        check("s1_d0",    wd[0],       32'h2008_0005);
        check("s1_a1",    wa[1],       32'h4);
        check("s1_d1",    wd[1],       32'h0109_5020);
        check("s1_ndone", done_n,      32'd1);
        check("s1_lat",   done_cyc - start_cyc, 32'd11);
        check("s1_err",   {31'd0, done_err}, 32'd0);
        settle();
        check("s1_hold",  {31'd0, cpu_hold}, 32'd0);

        // One word with in_valid toggling
        set_stream(32'hDEAD_BEEF, 32'h0, 32'h0);
        run_load(16'd1, 4, 1'b1, 1'b0, -1);
        check("s2_nwr",   wr_n,   32'd1);
        check("s2_a0",    wa[0],  32'h0);
        check("s2_d0",    wd[0],  32'hDEAD_BEEF);
        settle();

        // Zero-length load
        run_load(16'd0, 0, 1'b0, 1'b0, -1);
        check("s3_nwr",   wr_n,   32'd0);
        check("s3_ndone", done_n, 32'd1);
        check("s3_lat",   done_cyc - start_cyc, 32'd1);
        check("s3_err",   {31'd0, done_err}, 32'd0);
        settle();

        // Oversized load
        run_load(16'd257, 0, 1'b0, 1'b0, -1);
        check("s4_nwr",   wr_n,   32'd0);
        check("s4_ndone", done_n, 32'd1);
        check("s4_err",   {31'd0, done_err}, 32'd1);
        settle();
        check("s4_sticky", {31'd0, err}, 32'd1);

        // Start pulsed during RECV must be ignored
        set_stream(32'h1122_3344, 32'h5566_7788, 32'h0);
        run_load(16'd2, 8, 1'b0, 1'b1, -1);
        check("s5_nwr",   wr_n,   32'd2);
        check("s5_d0",    wd[0],  32'h1122_3344);
        check("s5_d1",    wd[1],  32'h5566_7788);
        check("s5_err",   {31'd0, done_err}, 32'd0);
        settle();

        // Reset after two bytes of word 1 of a three-word load
        set_stream(32'hA1B2_C3D4, 32'hE5F6_0718, 32'h292A_3B4C);
        run_load(16'd3, 12, 1'b0, 1'b0, 6);
        check("s6_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("s6_state", {24'd0, in_ready, im_we, cpu_hold, pc_reset, busy, done, err, 1'b0}, 32'd0);
        check("s6_addr",  im_addr,  32'h0);
        check("s6_wdata", im_wdata, 32'h0);
        check("s6_nwr",   wr_n,     32'd1);
        check("s6_d0",    wd[0],    32'hA1B2_C3D4);
        @(negedge clk);
        rst = 1'b0;
        set_stream(32'hCAFE_F00D, 32'h0, 32'h0);
        run_load(16'd1, 4, 1'b0, 1'b0, -1);
        check("s6_reload_nwr", wr_n,  32'd1);
        check("s6_reload_a0",  wa[0], 32'h0);
        check("s6_reload_d0",  wd[0], 32'hCAFE_F00D);
        settle();

        check("protocol_viol", viol, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
